// File: rtl/tp84_loader_pkg.sv
// tp84_loader_pkg
// Shared constants and types for the TimePilot84 ROM loader:
//   REG_BASE / REG_SIZE : byte offset and length of each ROM region in the
//                         flat index-0 download image
//   IMG_SIZE            : total image length; a complete load has exactly
//                         this many bytes
//   region_e            : region names, also the bit positions in rom_we
//   state_e             : loader FSM states
package tp84_loader_pkg;

    typedef enum logic [2:0] {
        REG_CPU1 = 3'd0,
        REG_CPU2 = 3'd1,
        REG_SND  = 3'd2,
        REG_CHAR = 3'd3,
        REG_SPR  = 3'd4,
        REG_PROM = 3'd5
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int NREG_TABLE = 6;

    // Indexed by region_e. Regions tile the image with no gaps.
    localparam logic [31:0] REG_BASE [NREG_TABLE] = '{
        32'h0_0000, 32'h0_8000, 32'h0_A000, 32'h0_C000, 32'h1_0000, 32'h1_8000
    };
    localparam logic [31:0] REG_SIZE [NREG_TABLE] = '{
        32'h8000, 32'h2000, 32'h2000, 32'h4000, 32'h8000, 32'h0800
    };

    localparam logic [31:0] IMG_SIZE = 32'h1_8800;

endpackage

// File: rtl/tp84_region_decode.sv
// tp84_region_decode
// Combinational decode of a flat image address into its ROM region.
// Ports:
//   addr     in  ADDR_W  image byte address
//   hit      out NREG    one-hot region match (all zero when out of image)
//   loc_addr out LOC_W   address relative to the matching region base
//   overflow out 1       address lies at or beyond the end of the image
module tp84_region_decode
    import tp84_loader_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int LOC_W  = 15,
    parameter int NREG   = 6
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NREG-1:0]   hit,
    output logic [LOC_W-1:0]  loc_addr,
    output logic              overflow
);

    logic [31:0] addr_ext;

    assign addr_ext = 32'(addr);

    always_comb begin
        hit      = '0;
        loc_addr = '0;
        overflow = (addr_ext >= IMG_SIZE);
        for (int i = 0; i < NREG; i++) begin
            if (addr_ext >= REG_BASE[i] && addr_ext < REG_BASE[i] + REG_SIZE[i]) begin
                hit[i]   = 1'b1;
                loc_addr = LOC_W'(addr_ext - REG_BASE[i]);
            end
        end
    end

endmodule

// File: rtl/tp84_rom_loader.sv
// tp84_rom_loader
// Bridges the HPS ioctl download stream to the TimePilot84 ROMs: splits the
// index-0 image into per-region write strobes, latches DIP bytes (index 254)
// and the set-3 flag (index 1), and reports whether a complete image loaded.
// Ports:
//   clk_49m, reset (sync, active-high)
//   ioctl_download/index/wr/addr/dout : HPS download stream
//   rom_we/rom_addr/rom_data          : registered region write port
//   dip_sw, is_set3                   : latched configuration
//   rom_ready, load_error             : image status
//   checksum (TP84_LOADER_CHECKSUM_EN only) : sum of counted image bytes
// Optional build macro TP84_LOADER_CHECKSUM_EN adds the checksum output and
// the EXP_SUM parameter (0 = do not compare).
//
// state | meaning
// IDLE  | no valid image; wait for an index-0 download to start
// LOAD  | index-0 download running; count bytes, note overflow
// CHECK | one cycle: judge byte count / overflow
// DONE  | valid image held; a new index-0 start reloads
module tp84_rom_loader
    import tp84_loader_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int LOC_W  = 15,
    parameter int NREG   = 6
`ifdef TP84_LOADER_CHECKSUM_EN
    , parameter logic [15:0] EXP_SUM = 16'h0000
`endif
) (
    input  logic              clk_49m,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [NREG-1:0]   rom_we,
    output logic [LOC_W-1:0]  rom_addr,
    output logic [7:0]        rom_data,
    output logic [15:0]       dip_sw,
    output logic              is_set3,
    output logic              rom_ready,
    output logic              load_error
`ifdef TP84_LOADER_CHECKSUM_EN
    , output logic [15:0]     checksum
`endif
);

    logic [NREG-1:0]   dec_hit;
    logic [LOC_W-1:0]  dec_loc;
    logic              dec_ovf;
    state_e            state;
    logic              dl_q;
    logic [ADDR_W-1:0] byte_cnt;
    logic              ovf_flag;
    logic              wr_img;
    logic              dl_rise;
    logic              dl_fall;
    logic              img_ok;

    tp84_region_decode #(
        .ADDR_W (ADDR_W),
        .LOC_W  (LOC_W),
        .NREG   (NREG)
    ) u_decode (
        .addr     (ioctl_addr),
        .hit      (dec_hit),
        .loc_addr (dec_loc),
        .overflow (dec_ovf)
    );

    assign wr_img  = ioctl_wr && (ioctl_index == 8'd0);
    assign dl_rise = ioctl_download && !dl_q;
    assign dl_fall = !ioctl_download && dl_q;

    always_comb begin
        img_ok = (32'(byte_cnt) == IMG_SIZE) && !ovf_flag;
`ifdef TP84_LOADER_CHECKSUM_EN
        if (EXP_SUM != 16'h0000 && checksum != EXP_SUM) begin
            img_ok = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            state      <= ST_IDLE;
            dl_q       <= 1'b0;
            byte_cnt   <= '0;
            ovf_flag   <= 1'b0;
            rom_we     <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
            dip_sw     <= 16'hFFFF;
            is_set3    <= 1'b0;
            rom_ready  <= 1'b0;
            load_error <= 1'b0;
`ifdef TP84_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            dl_q   <= ioctl_download;
            // Image bytes reach the ROMs in any state; only LOAD counts them.
            rom_we <= wr_img ? dec_hit : '0;
            if (wr_img) begin
                rom_addr <= dec_loc;
                rom_data <= ioctl_dout;
            end

            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[ADDR_W-1:3] == '0) begin
                if (ioctl_addr[2:0] == 3'd0) begin
                    dip_sw[7:0] <= ioctl_dout;
                end else if (ioctl_addr[2:0] == 3'd1) begin
                    dip_sw[15:8] <= ioctl_dout;
                end
            end

            if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == '0) begin
                is_set3 <= ioctl_dout[0];
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (dl_rise && ioctl_index == 8'd0) begin
                        state      <= ST_LOAD;
                        byte_cnt   <= '0;
                        ovf_flag   <= 1'b0;
                        rom_ready  <= 1'b0;
                        load_error <= 1'b0;
`ifdef TP84_LOADER_CHECKSUM_EN
                        checksum   <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    // A write coinciding with the falling edge still counts.
                    if (wr_img) begin
                        if (byte_cnt != '1) begin
                            byte_cnt <= byte_cnt + ADDR_W'(1);
                        end
                        if (dec_ovf) begin
                            ovf_flag <= 1'b1;
                        end
`ifdef TP84_LOADER_CHECKSUM_EN
                        checksum <= checksum + {8'h00, ioctl_dout};
`endif
                    end
                    if (dl_fall) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    rom_ready  <= img_ok;
                    load_error <= !img_ok;
                    state      <= img_ok ? ST_DONE : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tp84_rom_loader.md
Name: tp84_rom_loader

Overview:
- Sits between the HPS ioctl download stream and the TimePilot84 core.
- Splits the flat index-0 ROM image into per-region write strobes with region-local addresses.
- Latches the DIP bytes (index 254) and the set-3 flag (index 1, byte 0).
- Tracks download completeness and emits rom_ready, which the top level uses to hold the core in reset until a valid image has loaded.

Parameters:
- ADDR_W, 25: width of the ioctl address.
- LOC_W, 15: width of the region-local address output (largest region is 32 KiB).
- NREG, 6: number of ROM regions; must equal the length of the region table in the package.

Ports:
- clk_49m  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  byte strobe.
- ioctl_addr  in  ADDR_W  image byte address.
- ioctl_dout  in  8  image byte.
- rom_we  out  NREG  one-hot write strobe, one bit per region.
- rom_addr  out  LOC_W  region-local address.
- rom_data  out  8  write data.
- dip_sw  out  16  {dip byte1, dip byte0}, raw (active-low as delivered).
- is_set3  out  1  bit 0 of index-1 byte 0.
- rom_ready  out  1  a complete index-0 image has loaded.
- load_error  out  1  last index-0 download was short or overran the image.

Behaviour:
- Reset values:
  - rom_we=0, rom_addr=0, rom_data=0.
  - dip_sw=16'hFFFF, is_set3=0.
  - rom_ready=0, load_error=0.
  - FSM=IDLE, byte counter=0.
- Clocking: every output is registered. A rom_we pulse appears exactly 1 cycle after the qualifying ioctl_wr and lasts 1 cycle. rom_addr and rom_data are valid in that same cycle.
- Region decode, for ioctl_index==0 and ioctl_wr=1:
  - A region matches when ioctl_addr >= REG_BASE[i] and ioctl_addr < REG_BASE[i]+REG_SIZE[i].
  - On a match, rom_we[i]=1 and rom_addr = ioctl_addr - REG_BASE[i], truncated to LOC_W.
  - Regions are contiguous and non-overlapping, so at most one bit is set.
  - An address >= IMG_SIZE raises the overflow flag and produces no strobe.
- FSM states:
  - IDLE: on an ioctl_download rising edge with index==0, go to LOAD. Clear the counter and the overflow flag. rom_ready<=0, load_error<=0.
  - LOAD: increment the byte counter (saturating at 2^ADDR_W-1) on each index-0 write.
    - On ioctl_download falling, go to CHECK.
    - If ioctl_download rises again while the index is not 0, stay in LOAD. Writes for other indices are still processed, but do not count.
  - CHECK (1 cycle): ok = (counter==IMG_SIZE) and no overflow.
    - rom_ready<=ok, load_error<=!ok.
    - Go to DONE if ok, otherwise to IDLE.
  - DONE: hold rom_ready=1. A new index-0 download start goes to LOAD and drops rom_ready in the next cycle.
- DIP bytes: on ioctl_wr with index==254 and ioctl_addr[ADDR_W-1:3]==0:
  - addr[2:0]==0 writes dip_sw[7:0].
  - addr[2:0]==1 writes dip_sw[15:8].
  - addr[2:0] of 2..7 is accepted and dropped.
  - These writes are honoured in any FSM state.
- Set-3 flag: on ioctl_wr with index==1 and addr==0, is_set3 <= ioctl_dout[0].
- Simultaneous events: a write in the same cycle as the download falling edge is counted before CHECK.
- Reset mid-LOAD: return to IDLE with rom_ready=0. The partially written ROMs are left as-is; the next download overwrites them.

Optional Feature:
- Macro: TP84_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[15:0]: the 16-bit wrapping sum of every counted index-0 byte, cleared on LOAD entry.
  - Adds parameter EXP_SUM (default 16'h0000, meaning "don't check").
  - When EXP_SUM is non-zero, the CHECK condition additionally requires checksum==EXP_SUM.
- When undefined: the port and the check are absent, and behaviour is otherwise identical.

Decomposition:
- Package tp84_loader_pkg holds:
  - REG_BASE/REG_SIZE constant arrays: CPU1 0x00000/0x8000, CPU2 0x08000/0x2000, SND 0x0A000/0x2000, CHAR 0x0C000/0x4000, SPR 0x10000/0x8000, PROM 0x18000/0x0800.
  - IMG_SIZE=0x18800.
  - Region enum.
  - FSM state enum.
- Sub-module tp84_region_decode: combinational address-to-{hit one-hot, local address, overflow}, instantiated once.

Test Plan:
- Full index-0 download of 0x18800 bytes → CHECK passes; rom_ready=1 and load_error=0 two cycles after ioctl_download falls.
- Byte at addr 0x0A005 with data 0x5A → next cycle rom_we=6'b000100, rom_addr=0x0005, rom_data=0x5A.
- Short download of 0x18000 bytes → rom_ready=0, load_error=1, FSM=IDLE.
- Write at addr 0x18800 → no rom_we; load_error=1 at end even if the byte count matches.
- Index 254 writes 0x3F to addr 0 and 0xC2 to addr 1 → dip_sw=16'hC23F; the write to addr 8 is ignored. Index 1 addr 0 with data 0x01 → is_set3=1.
- reset asserted mid-LOAD, then a full reload → rom_ready stays 0 until the second download completes, then goes to 1. With TP84_LOADER_CHECKSUM_EN and a wrong EXP_SUM, load_error=1.
